cpu0_mem_arbiter: RTL and testbench



---
 rtl/cpu0_mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_cpu0_mem_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu0_mem_arbiter.sv
// cpu0_mem_arbiter: round-robin arbiter sharing the memory0 port between the cpu0 core
// (master 0) and a second bus master, with legality checking and fixed-length accesses.
module cpu0_mem_arbiter #(
    parameter int unsigned MEMSIZE       = 32'h10000,
    parameter int unsigned ACCESS_CYCLES = 1
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        m0_req,
    input  logic        m0_rw,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic        m0_err,
    output logic [31:0] m0_rdata,

    input  logic        m1_req,
    input  logic        m1_rw,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [31:0] m1_rdata,

    output logic        m_en,
    output logic        m_rw,
    output logic [1:0]  m_size,
    output logic [31:0] mar,
    output logic [31:0] mdr,
    input  logic [31:0] dbus,

    output logic [1:0]  grant,
    output logic        busy
);

    localparam logic [31:0] MaxAddr   = 32'(MEMSIZE - 4);
    localparam logic [3:0]  LastCount = 4'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic        last_q, last_d;
    logic        sel_q, sel_d;
    logic        reject_q, reject_d;
    logic [1:0]  grant_q, grant_d;
    logic        en_q, en_d;
    logic        rw_q, rw_d;
    logic [1:0]  size_q, size_d;
    logic [31:0] mar_q, mar_d;
    logic [31:0] mdr_q, mdr_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic        err0_q, err0_d;
    logic        err1_q, err1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;

    logic        pick;
    logic        req_rw;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_legal;

    // On a tie the master not granted last wins; last_q = 1 means master 1 went last.
    always_comb begin
        pick      = m1_req & (~m0_req | ~last_q);
        req_rw    = pick ? m1_rw    : m0_rw;
        req_size  = pick ? m1_size  : m0_size;
        req_addr  = pick ? m1_addr  : m0_addr;
        req_wdata = pick ? m1_wdata : m0_wdata;
        req_legal = (req_addr <= MaxAddr)
                    && !(req_size == 2'b11 && req_addr[1:0] != 2'b00)
                    && !(req_size == 2'b01 && req_addr[0]);
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        last_d   = last_q;
        sel_d    = sel_q;
        reject_d = reject_q;
        grant_d  = grant_q;
        en_d     = en_q;
        rw_d     = rw_q;
        size_d   = size_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        err0_d   = 1'b0;
        err1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    sel_d    = pick;
                    grant_d  = pick ? 2'b10 : 2'b01;
                    count_d  = '0;
                    reject_d = ~req_legal;
                    state_d  = StAccess;
                    if (req_legal) begin
                        en_d   = 1'b1;
                        rw_d   = req_rw;
                        size_d = req_size;
                        mar_d  = req_addr;
                        mdr_d  = req_wdata;
                    end
                end
            end
            // A rejected access spends one cycle here with m_en low so its ack lands
            // one edge after the request was sampled.
            StAccess: begin
                count_d = count_q + 4'd1;
                if (reject_q || count_q == LastCount) begin
                    state_d = StDone;
                    en_d    = 1'b0;
                    if (sel_q) begin
                        ack1_d = 1'b1;
                        err1_d = reject_q;
                    end else begin
                        ack0_d = 1'b1;
                        err0_d = reject_q;
                    end
                    if (reject_q) begin
                        if (sel_q) rdata1_d = '0;
                        else       rdata0_d = '0;
                    end else if (rw_q) begin
                        if (sel_q) rdata1_d = dbus;
                        else       rdata0_d = dbus;
                    end
                end
            end
            StDone: begin
                last_d  = sel_q;
                grant_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            count_q  <= '0;
            last_q   <= 1'b1;
            sel_q    <= 1'b0;
            reject_q <= 1'b0;
            grant_q  <= '0;
            en_q     <= 1'b0;
            rw_q     <= 1'b1;
            size_q   <= '0;
            mar_q    <= '0;
            mdr_q    <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            last_q   <= last_d;
            sel_q    <= sel_d;
            reject_q <= reject_d;
            grant_q  <= grant_d;
            en_q     <= en_d;
            rw_q     <= rw_d;
            size_q   <= size_d;
            mar_q    <= mar_d;
            mdr_q    <= mdr_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign m0_ack   = ack0_q;
    assign m0_err   = err0_q;
    assign m0_rdata = rdata0_q;
    assign m1_ack   = ack1_q;
    assign m1_err   = err1_q;
    assign m1_rdata = rdata1_q;
    assign m_en     = en_q;
    assign m_rw     = rw_q;
    assign m_size   = size_q;
    assign mar      = mar_q;
    assign mdr      = mdr_q;
    assign grant    = grant_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_cpu0_mem_arbiter.sv
// tb_cpu0_mem_arbiter: directed bench with a scoreboard of expected acks, a byte-addressed
// memory model on the N=1 instance and a second N=3 instance for access-length checks.
module tb_cpu0_mem_arbiter;

    localparam int Budget = 40;

    logic        clock = 1'b0;
    logic        reset;
    logic        m0_req, m1_req, m0_rw, m1_rw;
    logic [1:0]  m0_size, m1_size;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m_en, m_rw;
    logic [1:0]  m_size;
    logic [31:0] mar, mdr, dbus;
    logic [1:0]  grant;
    logic        busy;

    logic        s_ack0, s_ack1, s_err0, s_err1;
    logic [31:0] s_rdata0, s_rdata1;
    logic        s_en, s_rw;
    logic [1:0]  s_size;
    logic [31:0] s_mar, s_mdr, s_dbus;
    logic [1:0]  s_grant;
    logic        s_busy;

    typedef struct {
        int          m;
        logic        err;
        logic [31:0] rdata;
        logic        rd;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    cpu0_mem_arbiter #(.MEMSIZE(32'h10000), .ACCESS_CYCLES(1)) dut (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_rw(m1_rw), .m1_size(m1_size), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .mar(mar), .mdr(mdr), .dbus(dbus),
        .grant(grant), .busy(busy)
    );

    cpu0_mem_arbiter #(.MEMSIZE(32'h10000), .ACCESS_CYCLES(3)) dut3 (
        .clock(clock), .reset(reset),
        .m0_req(m0_req), .m0_rw(m0_rw), .m0_size(m0_size), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_ack(s_ack0), .m0_err(s_err0), .m0_rdata(s_rdata0),
        .m1_req(1'b0), .m1_rw(1'b1), .m1_size(2'b00), .m1_addr(32'h0),
        .m1_wdata(32'h0), .m1_ack(s_ack1), .m1_err(s_err1), .m1_rdata(s_rdata1),
        .m_en(s_en), .m_rw(s_rw), .m_size(s_size), .mar(s_mar), .mdr(s_mdr), .dbus(s_dbus),
        .grant(s_grant), .busy(s_busy)
    );

    // Little-endian byte memory; reads are zero-padded above the access size.
    logic [7:0] mem [0:65535];

    always_comb begin
        dbus = '0;
        for (int i = 0; i < 4; i++)
            if (i <= int'(m_size)) dbus[8*i +: 8] = mem[16'(mar + 32'(i))];
    end

    always @(posedge clock)
        if (m_en && !m_rw)
            for (int i = 0; i < 4; i++)
                if (i <= int'(m_size)) mem[16'(mar + 32'(i))] <= mdr[8*i +: 8];

    assign s_dbus = {16'hC0DE, s_mar[15:0]};

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic expire(input string tag);
        vectors++;
        miscompares++;
        $display("FAIL %s: observed no ack, expected ack within %0d cycles", tag, Budget);
    endtask

    task automatic drive(input int m, input logic req, input logic rw, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (m == 0) begin
            m0_req = req; m0_rw = rw; m0_size = size; m0_addr = addr; m0_wdata = wdata;
        end else begin
            m1_req = req; m1_rw = rw; m1_size = size; m1_addr = addr; m1_wdata = wdata;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " m_en"}, 32'(m_en), 32'd0);
        check({tag, " m_rw"}, 32'(m_rw), 32'd1);
        check({tag, " m_size"}, 32'(m_size), 32'd0);
        check({tag, " mar"}, mar, 32'd0);
        check({tag, " mdr"}, mdr, 32'd0);
        check({tag, " acks"}, {30'd0, m1_ack, m0_ack}, 32'd0);
        check({tag, " errs"}, {30'd0, m1_err, m0_err}, 32'd0);
        check({tag, " m0_rdata"}, m0_rdata, 32'd0);
        check({tag, " m1_rdata"}, m1_rdata, 32'd0);
        check({tag, " grant"}, 32'(grant), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd0);
    endtask

    // d selects the instance observed: 0 = N=1 with memory model, 1 = N=3 (master 0 only).
    task automatic run_txn(input string tag, input int d, input int m, input logic rw,
                           input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic exp_err,
                           input logic [31:0] exp_rdata, input int exp_lat, input int exp_en);
        int          cyc;
        int          en_cyc;
        bit          seen;
        bit          other;
        logic        err;
        logic [31:0] rdata;
        exp_t        e;
        e.m = m; e.err = exp_err; e.rdata = exp_rdata; e.rd = rw;
        sb.push_back(e);
        @(posedge clock); #1;
        drive(m, 1'b1, rw, size, addr, wdata);
        cyc = 0; en_cyc = 0; seen = 0; other = 0; err = 1'b0; rdata = '0;
        while (!seen && cyc < Budget) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if ((d == 1 ? s_en : m_en) === 1'b1) en_cyc++;
            if (cyc == 1)
                check({tag, " grant"}, 32'(d == 1 ? s_grant : grant),
                      (m == 0) ? 32'd1 : 32'd2);
            if (d == 1) begin
                if (s_ack1) other = 1;
                if (s_ack0) begin seen = 1; err = s_err0; rdata = s_rdata0; end
            end else if (m == 0) begin
                if (m1_ack) other = 1;
                if (m0_ack) begin seen = 1; err = m0_err; rdata = m0_rdata; end
            end else begin
                if (m0_ack) other = 1;
                if (m1_ack) begin seen = 1; err = m1_err; rdata = m1_rdata; end
            end
        end
        if (!seen) begin
            expire(tag);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            check({tag, " ack latency"}, 32'(cyc), 32'(exp_lat));
            check({tag, " m_en cycles"}, 32'(en_cyc), 32'(exp_en));
            check({tag, " err"}, 32'(err), 32'(e.err));
            if (e.rd) check({tag, " rdata"}, rdata, e.rdata);
            check({tag, " other ack"}, 32'(other), 32'd0);
        end
        @(posedge clock); #1;
        drive(m, 1'b0, rw, size, addr, wdata);
        if (d == 0) begin
            check({tag, " ack drops"}, {30'd0, m1_ack, m0_ack}, 32'd0);
            check({tag, " idle grant"}, 32'(grant), 32'd0);
            check({tag, " idle busy"}, 32'(busy), 32'd0);
        end
    endtask

    initial begin
        int   cyc;
        int   acks;
        int   mst;
        bit   stray;
        exp_t e;

        reset = 1'b1;
        drive(0, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b1, 2'b00, 32'h0, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        check_reset_state("reset");
        @(negedge clock);
        reset = 1'b0;

        // Preload and read back through both masters.
        run_txn("m0 wr32 0x100", 0, 0, 1'b0, 2'b11, 32'h100, 32'h12345678, 1'b0, 32'h0, 2, 1);
        run_txn("m0 rd32 0x100", 0, 0, 1'b1, 2'b11, 32'h100, 32'h0, 1'b0, 32'h12345678, 2, 1);
        run_txn("m1 wr32 0x200", 0, 1, 1'b0, 2'b11, 32'h200, 32'h11223344, 1'b0, 32'h0, 2, 1);
        run_txn("m1 wr8 0x203", 0, 1, 1'b0, 2'b00, 32'h203, 32'hFFFFFFAB, 1'b0, 32'h0, 2, 1);
        run_txn("m1 rd8 0x203", 0, 1, 1'b1, 2'b00, 32'h203, 32'h0, 1'b0, 32'h000000AB, 2, 1);
        run_txn("m1 rd32 0x200", 0, 1, 1'b1, 2'b11, 32'h200, 32'h0, 1'b0, 32'hAB223344, 2, 1);
        run_txn("m0 rd24 0x101", 0, 0, 1'b1, 2'b10, 32'h101, 32'h0, 1'b0, 32'h00123456, 2, 1);

        // Rejections and the top-of-memory boundary.
        run_txn("m0 rd32 0x102", 0, 0, 1'b1, 2'b11, 32'h102, 32'h0, 1'b1, 32'h0, 2, 0);
        run_txn("m0 rd32 0xFFFD", 0, 0, 1'b1, 2'b11, 32'hFFFD, 32'h0, 1'b1, 32'h0, 2, 0);
        run_txn("m0 rd16 0x101", 0, 0, 1'b1, 2'b01, 32'h101, 32'h0, 1'b1, 32'h0, 2, 0);
        run_txn("m0 rd8 0xFFFD", 0, 0, 1'b1, 2'b00, 32'hFFFD, 32'h0, 1'b1, 32'h0, 2, 0);
        run_txn("m0 wr8 0xFFFC", 0, 0, 1'b0, 2'b00, 32'hFFFC, 32'h0000005A, 1'b0, 32'h0, 2, 1);
        run_txn("m0 rd8 0xFFFC", 0, 0, 1'b1, 2'b00, 32'hFFFC, 32'h0, 1'b0, 32'h0000005A, 2, 1);
        check("m1_rdata untouched", m1_rdata, 32'hAB223344);

        // N=3 instance.
        repeat (10) @(posedge clock);
        run_txn("n3 rd32 0x104", 1, 0, 1'b1, 2'b11, 32'h104, 32'h0, 1'b0, 32'hC0DE0104, 4, 3);

        // Round-robin from reset with both masters requesting continuously.
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        check_reset_state("rr reset");
        @(posedge clock); #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            e.m = k % 2; e.err = 1'b0; e.rd = 1'b1;
            e.rdata = (k % 2 == 0) ? 32'h12345678 : 32'hAB223344;
            sb.push_back(e);
        end
        @(posedge clock); #1;
        drive(0, 1'b1, 1'b1, 2'b11, 32'h100, 32'h0);
        drive(1, 1'b1, 1'b1, 2'b11, 32'h200, 32'h0);
        cyc = 0; acks = 0;
        while (acks < 4 && cyc < Budget) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if (m0_ack || m1_ack) begin
                mst = m1_ack ? 1 : 0;
                e = sb.pop_front();
                check("rr master", 32'(mst), 32'(e.m));
                check("rr rdata", mst == 1 ? m1_rdata : m0_rdata, e.rdata);
                check("rr ack cycle", 32'(cyc), 32'(2 + 3 * acks));
                acks++;
            end
        end
        if (acks < 4) begin
            expire("rr");
            sb.delete();
        end
        @(posedge clock); #1;
        drive(0, 1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
        drive(1, 1'b0, 1'b1, 2'b11, 32'h200, 32'h0);
        repeat (4) @(posedge clock);

        // Reset in the middle of an access.
        @(posedge clock); #1;
        drive(0, 1'b1, 1'b1, 2'b11, 32'h100, 32'h0);
        @(posedge clock); #2;
        check("mid m_en before reset", 32'(m_en), 32'd1);
        reset = 1'b1;
        #1;
        check_reset_state("mid reset");
        drive(0, 1'b0, 1'b1, 2'b11, 32'h100, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        stray = 0;
        repeat (6) begin
            @(negedge clock);
            if (m0_ack || m1_ack || m_en) stray = 1;
        end
        check("no ack after reset", 32'(stray), 32'd0);
        run_txn("post reset rd32", 0, 0, 1'b1, 2'b11, 32'h100, 32'h0, 1'b0, 32'h12345678, 2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
